udp_pack: RTL and testbench

Transmit-side UDP encapsulator. It accepts a send request with ports, IP addresses and payload length from the application, then streams an 8-byte UDP header followed by the payload bytes into the IP packing layer. It sits between the application payload source and the IPv4 transmit block, mirroring the receive-side UDP unpacker. The UDP checksum is always transmitted as 0x0000 (permitted for IPv4). Fragmentation is handled downstream by the IP layer.

---
 rtl/udp_pack.sv | 205 ++++++++++++++++++++
 tb/tb_udp_pack.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/udp_pack.sv
`default_nettype none
// ============================================================================
// udp_pack : UDP transmit encapsulator, 8-byte header then payload, zero csum
// Revision : 1.0
// ============================================================================
module udp_pack #(
  parameter int unsigned MAX_LEN = 1472
) (
  input  logic        tx_clk,
  input  logic        rst,
  input  logic [31:0] src_ip_addr,
  input  logic [31:0] des_ip_addr,
  input  logic [15:0] src_port,
  input  logic [15:0] des_port,
  input  logic        udp_tx_req,
  input  logic [10:0] udp_tx_len,
  output logic        udp_tx_ack,
  output logic        udp_tx_err,
  input  logic        udp_dat_vld,
  input  logic [7:0]  udp_dat,
  output logic        udp_dat_rdy,
  output logic [31:0] trans_src_ip,
  output logic [31:0] trans_des_ip,
  output logic [7:0]  trans_prot_type,
  output logic [15:0] trans_pkt_len,
  output logic        trans_pkt_start,
  output logic        trans_pkt_en,
  output logic [7:0]  trans_pkt_dat,
  output logic        trans_pkt_end,
  input  logic        trans_pkt_rdy
);

  localparam logic [1:0]  S_IDLE    = 2'd0;
  localparam logic [1:0]  S_HEAD    = 2'd1;
  localparam logic [1:0]  S_DATA    = 2'd2;
  localparam logic [1:0]  S_DONE    = 2'd3;
  localparam logic [10:0] C_MAX_LEN = 11'(MAX_LEN);

  logic [1:0]  state_q, state_d;
  logic [10:0] byte_cnt_q, byte_cnt_d;
  logic [10:0] pay_len_q, pay_len_d;
  logic [15:0] pkt_len_q, pkt_len_d;
  logic [31:0] src_ip_q, src_ip_d;
  logic [31:0] des_ip_q, des_ip_d;
  logic [15:0] src_port_q, src_port_d;
  logic [15:0] des_port_q, des_port_d;
  logic        tx_ack_q, tx_ack_d;
  logic        tx_err_q, tx_err_d;
  logic        pkt_en_q, pkt_en_d;
  logic        pkt_start_q, pkt_start_d;
  logic        pkt_end_q, pkt_end_d;
  logic [7:0]  pkt_dat_q, pkt_dat_d;
  logic        load;
  logic [7:0]  head_byte;

  // Output byte register may take a new value when empty or being drained.
  assign load = !pkt_en_q || trans_pkt_rdy;

  always_comb begin
    head_byte = 8'h00;
    case (byte_cnt_q[2:0])
      3'd0:    head_byte = src_port_q[15:8];
      3'd1:    head_byte = src_port_q[7:0];
      3'd2:    head_byte = des_port_q[15:8];
      3'd3:    head_byte = des_port_q[7:0];
      3'd4:    head_byte = pkt_len_q[15:8];
      3'd5:    head_byte = pkt_len_q[7:0];
      default: head_byte = 8'h00;
    endcase
  end

  always_ff @(posedge tx_clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      byte_cnt_q  <= 11'd0;
      pay_len_q   <= 11'd0;
      pkt_len_q   <= 16'd0;
      src_ip_q    <= 32'd0;
      des_ip_q    <= 32'd0;
      src_port_q  <= 16'd0;
      des_port_q  <= 16'd0;
      tx_ack_q    <= 1'b0;
      tx_err_q    <= 1'b0;
      pkt_en_q    <= 1'b0;
      pkt_start_q <= 1'b0;
      pkt_end_q   <= 1'b0;
      pkt_dat_q   <= 8'd0;
    end else begin
      state_q     <= state_d;
      byte_cnt_q  <= byte_cnt_d;
      pay_len_q   <= pay_len_d;
      pkt_len_q   <= pkt_len_d;
      src_ip_q    <= src_ip_d;
      des_ip_q    <= des_ip_d;
      src_port_q  <= src_port_d;
      des_port_q  <= des_port_d;
      tx_ack_q    <= tx_ack_d;
      tx_err_q    <= tx_err_d;
      pkt_en_q    <= pkt_en_d;
      pkt_start_q <= pkt_start_d;
      pkt_end_q   <= pkt_end_d;
      pkt_dat_q   <= pkt_dat_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    byte_cnt_d  = byte_cnt_q;
    pay_len_d   = pay_len_q;
    pkt_len_d   = pkt_len_q;
    src_ip_d    = src_ip_q;
    des_ip_d    = des_ip_q;
    src_port_d  = src_port_q;
    des_port_d  = des_port_q;
    tx_ack_d    = 1'b0;
    tx_err_d    = 1'b0;
    pkt_en_d    = pkt_en_q;
    pkt_start_d = pkt_start_q;
    pkt_end_d   = pkt_end_q;
    pkt_dat_d   = pkt_dat_q;
    case (state_q)
      S_IDLE: begin
        if (load) begin
          pkt_en_d    = 1'b0;
          pkt_start_d = 1'b0;
          pkt_end_d   = 1'b0;
        end
        if (udp_tx_req) begin
          if (udp_tx_len <= C_MAX_LEN) begin
            src_ip_d   = src_ip_addr;
            des_ip_d   = des_ip_addr;
            src_port_d = src_port;
            des_port_d = des_port;
            pay_len_d  = udp_tx_len;
            pkt_len_d  = {5'd0, udp_tx_len} + 16'd8;
            byte_cnt_d = 11'd0;
            tx_ack_d   = 1'b1;
            state_d    = S_HEAD;
          end else begin
            tx_err_d = 1'b1;
          end
        end
      end
      S_HEAD: begin
        if (load) begin
          pkt_en_d    = 1'b1;
          pkt_dat_d   = head_byte;
          pkt_start_d = (byte_cnt_q == 11'd0);
          pkt_end_d   = (byte_cnt_q == 11'd7) && (pay_len_q == 11'd0);
          if (byte_cnt_q == 11'd7) begin
            byte_cnt_d = 11'd0;
            state_d    = (pay_len_q == 11'd0) ? S_DONE : S_DATA;
          end else begin
            byte_cnt_d = byte_cnt_q + 11'd1;
          end
        end
      end
      S_DATA: begin
        if (load) begin
          pkt_start_d = 1'b0;
          if (udp_dat_vld) begin
            pkt_en_d   = 1'b1;
            pkt_dat_d  = udp_dat;
            pkt_end_d  = (byte_cnt_q == pay_len_q - 11'd1);
            byte_cnt_d = byte_cnt_q + 11'd1;
            if (byte_cnt_q == pay_len_q - 11'd1) begin
              state_d = S_DONE;
            end
          end else begin
            // Source gap: stall rather than pad.
            pkt_en_d  = 1'b0;
            pkt_end_d = 1'b0;
          end
        end
      end
      S_DONE: begin
        if (load) begin
          pkt_en_d    = 1'b0;
          pkt_start_d = 1'b0;
          pkt_end_d   = 1'b0;
          byte_cnt_d  = 11'd0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    udp_dat_rdy = (state_q == S_DATA) && load;
  end

  assign udp_tx_ack      = tx_ack_q;
  assign udp_tx_err      = tx_err_q;
  assign trans_src_ip    = src_ip_q;
  assign trans_des_ip    = des_ip_q;
  assign trans_prot_type = 8'h11;
  assign trans_pkt_len   = pkt_len_q;
  assign trans_pkt_start = pkt_start_q;
  assign trans_pkt_en    = pkt_en_q;
  assign trans_pkt_dat   = pkt_dat_q;
  assign trans_pkt_end   = pkt_end_q;

endmodule
`default_nettype wire

// File: tb/tb_udp_pack.sv
`default_nettype none
// tb_udp_pack: vector table plus byte scoreboard for udp_pack.
module tb_udp_pack;

  logic        tx_clk = 1'b0;
  logic        rst;
  logic [31:0] src_ip_addr, des_ip_addr;
  logic [15:0] src_port, des_port;
  logic        udp_tx_req;
  logic [10:0] udp_tx_len;
  logic        udp_tx_ack, udp_tx_err;
  logic        udp_dat_vld;
  logic [7:0]  udp_dat;
  logic        udp_dat_rdy;
  logic [31:0] trans_src_ip, trans_des_ip;
  logic [7:0]  trans_prot_type;
  logic [15:0] trans_pkt_len;
  logic        trans_pkt_start, trans_pkt_en, trans_pkt_end, trans_pkt_rdy;
  logic [7:0]  trans_pkt_dat;

  udp_pack #(.MAX_LEN(1472)) dut (
    .tx_clk          (tx_clk),
    .rst             (rst),
    .src_ip_addr     (src_ip_addr),
    .des_ip_addr     (des_ip_addr),
    .src_port        (src_port),
    .des_port        (des_port),
    .udp_tx_req      (udp_tx_req),
    .udp_tx_len      (udp_tx_len),
    .udp_tx_ack      (udp_tx_ack),
    .udp_tx_err      (udp_tx_err),
    .udp_dat_vld     (udp_dat_vld),
    .udp_dat         (udp_dat),
    .udp_dat_rdy     (udp_dat_rdy),
    .trans_src_ip    (trans_src_ip),
    .trans_des_ip    (trans_des_ip),
    .trans_prot_type (trans_prot_type),
    .trans_pkt_len   (trans_pkt_len),
    .trans_pkt_start (trans_pkt_start),
    .trans_pkt_en    (trans_pkt_en),
    .trans_pkt_dat   (trans_pkt_dat),
    .trans_pkt_end   (trans_pkt_end),
    .trans_pkt_rdy   (trans_pkt_rdy)
  );

  always #5 tx_clk = ~tx_clk;

  typedef struct {
    string       name;
    logic [15:0] sp;
    logic [15:0] dp;
    logic [10:0] len;
    logic [7:0]  base;
    logic [7:0]  step;
    bit          rdy_rand;
    bit          vld_rand;
    bit          exp_err;
    logic [15:0] exp_len;
  } vec_t;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [9:0]  exp_q[$];
  logic [7:0]  pay_q[$];
  bit          rdy_rand = 1'b0;
  bit          vld_rand = 1'b0;
  logic        dat_fire = 1'b0;
  int          cyc = 0;
  int          acc_first = -1;
  int          acc_last = -1;
  int          end_cyc = -1;
  int          acc_count = 0;
  int          dat_rdy_hits = 0;
  logic        prev_stall = 1'b0;
  logic        prev_rst = 1'b1;
  logic [10:0] prev_word = 11'd0;
  logic [9:0]  mon_e;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge tx_clk);
    #2;
  endtask

  task automatic push_pkt(input logic [15:0] sp, input logic [15:0] dp, input logic [10:0] len,
                          input logic [15:0] plen, input logic [7:0] base, input logic [7:0] step);
    logic [7:0] hdr [8];
    logic [7:0] b;
    hdr[0] = sp[15:8];   hdr[1] = sp[7:0];
    hdr[2] = dp[15:8];   hdr[3] = dp[7:0];
    hdr[4] = plen[15:8]; hdr[5] = plen[7:0];
    hdr[6] = 8'h00;      hdr[7] = 8'h00;
    for (int i = 0; i < 8; i++)
      exp_q.push_back({(i == 0), (i == 7 && len == 11'd0), hdr[i]});
    for (int i = 0; i < int'(len); i++) begin
      b = base + 8'(i) * step;
      pay_q.push_back(b);
      exp_q.push_back({1'b0, (i == int'(len) - 1), b});
    end
  endtask

  task automatic wait_resp(output int waited, output logic got_ack, output logic got_err);
    waited = 0; got_ack = 1'b0; got_err = 1'b0;
    while (!got_ack && !got_err && waited < 20) begin
      tick();
      waited++;
      got_ack = udp_tx_ack;
      got_err = udp_tx_err;
    end
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() > 0 && n < 6000) begin
      tick();
      n++;
    end
    chk({name, "_drain"}, 32'(exp_q.size()), 32'd0);
    tick();
    chk({name, "_en_low_after"}, 32'(trans_pkt_en), 32'd0);
  endtask

  task automatic run_vec(input vec_t v);
    int          waited;
    int          en_seen;
    logic        got_ack, got_err;
    logic [31:0] sip, dip;
    sip = $urandom;
    dip = $urandom;
    rdy_rand = v.rdy_rand;
    vld_rand = v.vld_rand;
    dat_rdy_hits = 0;
    acc_first = -1;
    acc_last = -1;
    if (!v.exp_err) push_pkt(v.sp, v.dp, v.len, v.exp_len, v.base, v.step);
    src_ip_addr = sip; des_ip_addr = dip;
    src_port = v.sp;   des_port = v.dp;
    udp_tx_len = v.len;
    udp_tx_req = 1'b1;
    wait_resp(waited, got_ack, got_err);
    udp_tx_req = 1'b0;
    chk({v.name, "_ack"}, 32'(got_ack), 32'(!v.exp_err));
    chk({v.name, "_err"}, 32'(got_err), 32'(v.exp_err));
    chk({v.name, "_resp_latency"}, 32'(waited), 32'd1);
    if (v.exp_err) begin
      en_seen = 0;
      for (int i = 0; i < 5; i++) begin
        tick();
        if (trans_pkt_en || udp_tx_ack) en_seen++;
      end
      chk({v.name, "_no_output"}, 32'(en_seen), 32'd0);
      chk({v.name, "_no_dat_rdy"}, 32'(dat_rdy_hits), 32'd0);
    end else begin
      chk({v.name, "_pkt_len"}, 32'(trans_pkt_len), 32'(v.exp_len));
      chk({v.name, "_src_ip"}, trans_src_ip, sip);
      chk({v.name, "_des_ip"}, trans_des_ip, dip);
      tick();
      chk({v.name, "_first_byte"}, 32'({trans_pkt_en, trans_pkt_start, trans_pkt_dat}),
          32'({2'b11, v.sp[15:8]}));
      wait_drain(v.name);
      if (!v.rdy_rand && !v.vld_rand)
        chk({v.name, "_span"}, 32'(acc_last - acc_first), 32'(7 + int'(v.len)));
      if (v.len == 11'd0)
        chk({v.name, "_no_dat_rdy"}, 32'(dat_rdy_hits), 32'd0);
    end
    rdy_rand = 1'b0;
    vld_rand = 1'b0;
  endtask

  // Payload source and downstream ready driver.
  initial begin
    udp_dat_vld = 1'b0;
    udp_dat = 8'h00;
    trans_pkt_rdy = 1'b1;
    forever begin
      @(posedge tx_clk);
      #1;
      if (dat_fire && pay_q.size() > 0) void'(pay_q.pop_front());
      trans_pkt_rdy = rdy_rand ? 1'($urandom_range(1, 0)) : 1'b1;
      if (pay_q.size() > 0 && (!vld_rand || $urandom_range(2, 0) != 0)) begin
        udp_dat_vld = 1'b1;
        udp_dat = pay_q[0];
      end else begin
        udp_dat_vld = 1'b0;
      end
    end
  end

  // Output monitor and scoreboard.
  initial begin
    forever begin
      @(negedge tx_clk);
      cyc++;
      dat_fire = udp_dat_vld && udp_dat_rdy;
      if (udp_dat_rdy === 1'b1) dat_rdy_hits++;
      if (prev_stall === 1'b1 && prev_rst === 1'b0)
        chk("hold_stable", 32'({trans_pkt_en, trans_pkt_start, trans_pkt_end, trans_pkt_dat}),
            32'(prev_word));
      if (trans_pkt_en === 1'b1 && trans_pkt_rdy) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_byte: got %0h expected none", trans_pkt_dat);
        end else begin
          mon_e = exp_q.pop_front();
          chk("byte", 32'({trans_pkt_start, trans_pkt_end, trans_pkt_dat}), 32'(mon_e));
          if (acc_first < 0) acc_first = cyc;
          acc_last = cyc;
          if (trans_pkt_end) end_cyc = cyc;
          acc_count++;
        end
      end
      prev_stall = trans_pkt_en && !trans_pkt_rdy;
      prev_word  = {trans_pkt_en, trans_pkt_start, trans_pkt_end, trans_pkt_dat};
      prev_rst   = rst;
    end
  end

  vec_t vecs[6];

  initial begin
    int   waited, n, c2, base_cnt, en_seen;
    logic got_ack, got_err;
    vec_t after_rst;

    vecs[0] = '{"len4",    16'h1234, 16'h5678, 11'd4,    8'hAA, 8'h11, 1'b0, 1'b0, 1'b0, 16'h000C};
    vecs[1] = '{"len0",    16'h0001, 16'h0002, 11'd0,    8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 16'h0008};
    vecs[2] = '{"len1473", 16'h0003, 16'h0004, 11'd1473, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 16'h0000};
    vecs[3] = '{"len1472", 16'hC000, 16'h0035, 11'd1472, 8'h00, 8'h01, 1'b0, 1'b0, 1'b0, 16'h05C8};
    vecs[4] = '{"len100s", 16'h4321, 16'h8765, 11'd100,  8'h10, 8'h03, 1'b1, 1'b1, 1'b0, 16'h006C};
    vecs[5] = '{"len1",    16'hFFFF, 16'h0000, 11'd1,    8'h5A, 8'h00, 1'b0, 1'b0, 1'b0, 16'h0009};
    after_rst = '{"post_rst", 16'h0BAD, 16'hF00D, 11'd2, 8'hE0, 8'h07, 1'b0, 1'b0, 1'b0, 16'h000A};

    rst = 1'b1;
    src_ip_addr = 32'd0; des_ip_addr = 32'd0;
    src_port = 16'd0; des_port = 16'd0;
    udp_tx_req = 1'b0; udp_tx_len = 11'd0;
    repeat (3) tick();
    chk("rst_pkt_ctl", 32'({trans_pkt_en, trans_pkt_start, trans_pkt_end, trans_pkt_dat}), 32'd0);
    chk("rst_handshake", 32'({udp_tx_ack, udp_tx_err, udp_dat_rdy}), 32'd0);
    chk("rst_fields", 32'(trans_src_ip | trans_des_ip | {16'd0, trans_pkt_len}), 32'd0);
    chk("rst_prot", 32'(trans_prot_type), 32'h11);
    rst = 1'b0;
    tick();

    for (int i = 0; i < 6; i++) run_vec(vecs[i]);

    // Request held high across two datagrams.
    end_cyc = -1;
    push_pkt(16'h0A0B, 16'h0C0D, 11'd3, 16'h000B, 8'h30, 8'h01);
    push_pkt(16'h0E0F, 16'h1011, 11'd5, 16'h000D, 8'h40, 8'h01);
    src_port = 16'h0A0B; des_port = 16'h0C0D; udp_tx_len = 11'd3;
    udp_tx_req = 1'b1;
    wait_resp(waited, got_ack, got_err);
    chk("b2b_ack1", 32'(got_ack), 32'd1);
    src_port = 16'h0E0F; des_port = 16'h1011; udp_tx_len = 11'd5;
    n = 0;
    got_ack = 1'b0;
    while (!got_ack && n < 100) begin
      tick();
      n++;
      got_ack = udp_tx_ack;
    end
    c2 = cyc;
    udp_tx_req = 1'b0;
    chk("b2b_ack2", 32'(got_ack), 32'd1);
    chk("b2b_ack2_after_end", 32'(c2 - end_cyc), 32'd1);
    chk("b2b_pkt_len2", 32'(trans_pkt_len), 32'h000D);
    wait_drain("b2b");

    // Reset in the middle of a 100-byte payload.
    base_cnt = acc_count;
    push_pkt(16'h2222, 16'h3333, 11'd100, 16'h006C, 8'h00, 8'h01);
    src_port = 16'h2222; des_port = 16'h3333; udp_tx_len = 11'd100;
    udp_tx_req = 1'b1;
    wait_resp(waited, got_ack, got_err);
    udp_tx_req = 1'b0;
    chk("midrst_ack", 32'(got_ack), 32'd1);
    n = 0;
    while (acc_count < base_cnt + 58 && n < 500) begin
      tick();
      n++;
    end
    chk("midrst_reached_byte50", 32'(acc_count >= base_cnt + 58), 32'd1);
    rst = 1'b1;
    tick();
    chk("midrst_pkt_ctl", 32'({trans_pkt_en, trans_pkt_start, trans_pkt_end, trans_pkt_dat}), 32'd0);
    chk("midrst_handshake", 32'({udp_tx_ack, udp_tx_err, udp_dat_rdy}), 32'd0);
    chk("midrst_fields", 32'(trans_src_ip | trans_des_ip | {16'd0, trans_pkt_len}), 32'd0);
    chk("midrst_prot", 32'(trans_prot_type), 32'h11);
    rst = 1'b0;
    exp_q.delete();
    pay_q.delete();
    udp_dat_vld = 1'b0;
    en_seen = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (trans_pkt_en || trans_pkt_end || udp_dat_rdy) en_seen++;
    end
    chk("midrst_quiet", 32'(en_seen), 32'd0);
    run_vec(after_rst);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
